data_sram_responder: RTL and testbench

//   SRAM-like data-side responder (slave) for the CPU pipeline. Accepts requests on
//   the data_sram_* req/addr_ok channel and returns responses on the

---
 rtl/data_sram_responder.sv | 95 +++++++++
 tb/tb_data_sram_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - SRAM-like data-side responder with in-order, fixed-latency responses
// Word RAM plus an outstanding-request FIFO whose entries count down to their data_ok cycle.
module data_sram_responder #(
   parameter int ADDR_W = 10,
   parameter int DEPTH  = 2,
   parameter int DELAY  = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int CD_W  = (DELAY > 1) ? $clog2(DELAY) : 1;

   logic [31:0]       mem       [2**ADDR_W];
   logic [31:0]       fifo_data [DEPTH];
   logic              fifo_read [DEPTH];
   logic [CD_W-1:0]   fifo_cd   [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [CNT_W-1:0]  count;
   logic [ADDR_W-1:0] idx;
   logic              push;
   logic              pop;
   logic              head_due;
   logic              unused_bits;

   // Size is informational only; upper address bits alias onto the RAM.
   assign idx         = data_sram_addr[ADDR_W+1:2];
   assign unused_bits = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

   assign data_sram_addr_ok = !reset && (count != CNT_W'(DEPTH));
   assign push              = data_sram_req && data_sram_addr_ok;
   assign head_due          = (count != '0) && (fifo_cd[rd_ptr] == '0);
   assign pop               = !reset && head_due;
   assign data_sram_data_ok = pop;
   assign data_sram_rdata   = (pop && fifo_read[rd_ptr]) ? fifo_data[rd_ptr] : 32'h0;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge clk) begin
      if (push && data_sram_wr) begin
         for (int i = 0; i < 4; i++) begin
            if (data_sram_wstrb[i])
               mem[idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
         end
      end
   end

   // The read word is captured at acceptance, so earlier writes are already visible.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_data[wr_ptr] <= data_sram_wr ? 32'h0 : mem[idx];
         fifo_read[wr_ptr] <= !data_sram_wr;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++)
            fifo_cd[i] <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_inc(wr_ptr);
         if (pop)
            rd_ptr <= ptr_inc(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         for (int i = 0; i < DEPTH; i++) begin
            if (push && (wr_ptr == PTR_W'(i)))
               fifo_cd[i] <= CD_W'(DELAY - 1);
            else if (fifo_cd[i] != '0)
               fifo_cd[i] <= fifo_cd[i] - 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - bench for data_sram_responder over three DEPTH/DELAY configurations
// A timestamp-queue reference model predicts addr_ok, data_ok and rdata every cycle.
module tb_data_sram_responder;
   localparam int N = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_i   [N];
   logic        wr_i    [N];
   logic [1:0]  size_i  [N];
   logic [3:0]  strb_i  [N];
   logic [31:0] addr_i  [N];
   logic [31:0] wdata_i [N];
   logic        aok     [N];
   logic        dok     [N];
   logic [31:0] rdata   [N];

   always #5 clk = ~clk;

   data_sram_responder #(.ADDR_W(10), .DEPTH(2), .DELAY(1)) u_d0 (
      .clk(clk), .reset(reset), .data_sram_req(req_i[0]), .data_sram_wr(wr_i[0]),
      .data_sram_size(size_i[0]), .data_sram_wstrb(strb_i[0]), .data_sram_addr(addr_i[0]),
      .data_sram_wdata(wdata_i[0]), .data_sram_addr_ok(aok[0]), .data_sram_data_ok(dok[0]),
      .data_sram_rdata(rdata[0]));

   data_sram_responder #(.ADDR_W(10), .DEPTH(2), .DELAY(3)) u_d1 (
      .clk(clk), .reset(reset), .data_sram_req(req_i[1]), .data_sram_wr(wr_i[1]),
      .data_sram_size(size_i[1]), .data_sram_wstrb(strb_i[1]), .data_sram_addr(addr_i[1]),
      .data_sram_wdata(wdata_i[1]), .data_sram_addr_ok(aok[1]), .data_sram_data_ok(dok[1]),
      .data_sram_rdata(rdata[1]));

   data_sram_responder #(.ADDR_W(10), .DEPTH(3), .DELAY(2)) u_d2 (
      .clk(clk), .reset(reset), .data_sram_req(req_i[2]), .data_sram_wr(wr_i[2]),
      .data_sram_size(size_i[2]), .data_sram_wstrb(strb_i[2]), .data_sram_addr(addr_i[2]),
      .data_sram_wdata(wdata_i[2]), .data_sram_addr_ok(aok[2]), .data_sram_data_ok(dok[2]),
      .data_sram_rdata(rdata[2]));

   // Reference state: RAM image plus a queue of pending responses stamped with their due cycle.
   logic [31:0] mem_m  [N][1024];
   int          q_due  [N][8];
   logic [31:0] q_data [N][8];
   bit          q_rd   [N][8];
   int          q_n    [N];
   bit          acc    [N];
   bit          aok_s  [N];
   int          dok_cnt[N];
   logic [31:0] last_rd[N];
   int          cyc;
   int          vectors;
   int          miscompares;
   logic [4:0]  pat;
   int          base;

   function automatic int depth_of(input int k);
      case (k)
         0: return 2;
         1: return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int delay_of(input int k);
      case (k)
         0: return 1;
         1: return 3;
         default: return 2;
      endcase
   endfunction

   task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s[%0d] cyc %0d: observed %h expected %h", tag, k, cyc, obs, exp);
      end
   endtask

   task automatic step(input int k);
      bit          e_aok;
      bit          e_dok;
      logic [31:0] e_rd;
      int          idx;
      e_aok = !reset && (q_n[k] != depth_of(k));
      e_dok = !reset && (q_n[k] != 0) && (q_due[k][0] == cyc);
      e_rd  = (e_dok && q_rd[k][0]) ? q_data[k][0] : 32'h0;
      chk("addr_ok", k, {31'b0, aok[k]}, {31'b0, e_aok});
      chk("data_ok", k, {31'b0, dok[k]}, {31'b0, e_dok});
      chk("rdata", k, rdata[k], e_rd);
      aok_s[k] = (aok[k] === 1'b1);
      if (dok[k] === 1'b1) begin
         dok_cnt[k]++;
         last_rd[k] = rdata[k];
      end
      acc[k] = 1'b0;
      if (reset) begin
         q_n[k] = 0;
      end else begin
         if (e_dok) begin
            for (int i = 0; i < 7; i++) begin
               q_due[k][i]  = q_due[k][i+1];
               q_data[k][i] = q_data[k][i+1];
               q_rd[k][i]   = q_rd[k][i+1];
            end
            q_n[k]--;
         end
         if (req_i[k] && e_aok) begin
            acc[k] = 1'b1;
            idx = int'(addr_i[k][11:2]);
            if (wr_i[k]) begin
               for (int b = 0; b < 4; b++)
                  if (strb_i[k][b]) mem_m[k][idx][8*b +: 8] = wdata_i[k][8*b +: 8];
            end
            q_due[k][q_n[k]]  = cyc + delay_of(k);
            q_data[k][q_n[k]] = wr_i[k] ? 32'h0 : mem_m[k][idx];
            q_rd[k][q_n[k]]   = !wr_i[k];
            q_n[k]++;
         end
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < N; k++) step(k);
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic issue(input int k, input bit wr, input logic [3:0] strb,
                        input logic [31:0] a, input logic [31:0] d);
      int n;
      n = 0;
      req_i[k] = 1'b1; wr_i[k] = wr; strb_i[k] = strb; addr_i[k] = a; wdata_i[k] = d;
      size_i[k] = 2'd2;
      do begin
         tick();
         n++;
      end while (!acc[k] && n < 20);
      req_i[k] = 1'b0;
      chk("accept_timeout", k, {31'b0, acc[k]}, 32'd1);
   endtask

   initial begin
      reset = 1'b1;
      cyc = 0; vectors = 0; miscompares = 0;
      for (int k = 0; k < N; k++) begin
         req_i[k] = 1'b0; wr_i[k] = 1'b0; size_i[k] = 2'd2; strb_i[k] = 4'h0;
         addr_i[k] = 32'h0; wdata_i[k] = 32'h0;
         q_n[k] = 0; acc[k] = 1'b0; aok_s[k] = 1'b0; dok_cnt[k] = 0; last_rd[k] = 32'h0;
      end
      idle(3);
      reset = 1'b0;
      tick();
      for (int k = 0; k < N; k++) chk("post_reset_addr_ok", k, {31'b0, aok_s[k]}, 32'd1);

      // Give every word the random phase can touch a known value.
      for (int k = 0; k < N; k++)
         for (int i = 0; i < 16; i++) issue(k, 1'b1, 4'hF, 32'(i * 4), $urandom());
      idle(4);

      issue(0, 1'b1, 4'hF, 32'h1C, 32'h12345678);
      issue(0, 1'b0, 4'h0, 32'h1C, 32'h0);
      idle(2);
      chk("raw_1c", 0, last_rd[0], 32'h12345678);

      issue(0, 1'b1, 4'hF, 32'h20, 32'hAABBCCDD);
      issue(0, 1'b1, 4'h2, 32'h20, 32'h0000EE00);
      issue(0, 1'b0, 4'h0, 32'h20, 32'h0);
      idle(2);
      chk("lane_merge_20", 0, last_rd[0], 32'hAABBEEDD);

      issue(0, 1'b1, 4'hF, 32'h4, 32'h5A5AA5A5);
      issue(0, 1'b0, 4'h0, 32'h1000_0004, 32'h0);
      idle(2);
      chk("alias_1000_0004", 0, last_rd[0], 32'h5A5AA5A5);

      issue(0, 1'b1, 4'h0, 32'h8, 32'hFFFFFFFF);
      issue(0, 1'b0, 4'h0, 32'h8, 32'h0);
      idle(2);
      chk("zero_strb", 0, last_rd[0], mem_m[0][2]);

      idle(5);
      req_i[1] = 1'b1; wr_i[1] = 1'b0; addr_i[1] = 32'h0; pat = '0;
      for (int c = 0; c < 5; c++) begin
         tick();
         pat = {pat[3:0], aok_s[1]};
         if (acc[1]) addr_i[1] = addr_i[1] + 32'd4;
      end
      req_i[1] = 1'b0;
      chk("addr_ok_pattern", 1, {27'b0, pat}, 32'h19);
      idle(6);
      chk("pattern_last_word", 1, last_rd[1], mem_m[1][2]);

      issue(1, 1'b0, 4'h0, 32'h10, 32'h0);
      issue(1, 1'b0, 4'h0, 32'h14, 32'h0);
      base = dok_cnt[1];
      reset = 1'b1;
      idle(2);
      reset = 1'b0;
      tick();
      chk("addr_ok_after_reset", 1, {31'b0, aok_s[1]}, 32'd1);
      idle(5);
      chk("no_stale_data_ok", 1, 32'(dok_cnt[1] - base), 32'd0);
      issue(1, 1'b1, 4'hF, 32'h3C, 32'h0BADCAFE);
      issue(1, 1'b0, 4'h0, 32'h3C, 32'h0);
      idle(4);
      chk("read_after_reset", 1, last_rd[1], 32'h0BADCAFE);

      for (int c = 0; c < 800; c++) begin
         reset = (c == 400);
         for (int k = 0; k < N; k++) begin
            req_i[k]   = ($urandom_range(0, 9) < 7);
            wr_i[k]    = $urandom_range(0, 1) == 1;
            size_i[k]  = 2'($urandom_range(0, 2));
            strb_i[k]  = 4'($urandom_range(0, 15));
            addr_i[k]  = ($urandom() & 32'hFFFF_F003) | (32'($urandom_range(0, 15)) << 2);
            wdata_i[k] = $urandom();
         end
         tick();
      end
      reset = 1'b0;
      for (int k = 0; k < N; k++) req_i[k] = 1'b0;
      idle(8);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
